// File: rtl/ray_dispatcher.sv
// Buffers camera rays from the generator in a small FIFO and issues them
// round-robin to a pool of ray units, reporting aggregate busy upstream.
module ray_dispatcher #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int NUM_UNITS      = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic signed [2:0][POSITION_WIDTH-1:0]  rayV,
  input  logic        [ADDRESS_WIDTH-1:0]        rayAddress,
  input  logic                                   rayStart,
  output logic                                   rayReady,
  output logic                                   rayBusy,
  output logic signed [2:0][POSITION_WIDTH-1:0]  unitV,
  output logic        [ADDRESS_WIDTH-1:0]        unitAddress,
  output logic        [NUM_UNITS-1:0]            unitStart,
  input  logic        [NUM_UNITS-1:0]            unitReady,
  input  logic        [NUM_UNITS-1:0]            unitBusy,
  output logic        [31:0]                     dispatched
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W    = $clog2(NUM_UNITS);
  localparam int V_W     = 3 * POSITION_WIDTH;
  localparam int ENTRY_W = V_W + ADDRESS_WIDTH;

  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic [RR_W-1:0]      rr_reg;
  logic [RR_W-1:0]      rr_next;
  logic [RR_W-1:0]      grant_idx;
  logic [RR_W-1:0]      cand_idx [NUM_UNITS];
  logic [NUM_UNITS-1:0] unit_start_reg;
  logic [NUM_UNITS-1:0] eligible;
  logic [NUM_UNITS-1:0] grant_onehot;
  logic                 grant_valid;
  logic                 push;
  logic                 pop;
  logic [V_W-1:0]       unit_v_reg;
  logic [ADDRESS_WIDTH-1:0] unit_addr_reg;
  logic [31:0]          dispatched_reg;

  assign rayReady = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push     = rayStart && rayReady;

  // The start register doubles as the one-cycle grant mask: a unit whose
  // pulse is currently visible may still show ready and must not be regranted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign eligible[gi] = unitReady[gi] && !unit_start_reg[gi];
      assign cand_idx[gi] = RR_W'((int'(rr_reg) + gi) % NUM_UNITS);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest eligible one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (eligible[cand_idx[k]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign grant_onehot = NUM_UNITS'(1) << grant_idx;
  assign rr_next      = (grant_idx == RR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + RR_W'(1);
  assign pop          = (count_reg != '0) && grant_valid;
  assign head         = fifo_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it maps onto RAM; validity lives in count_reg.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {rayV, rayAddress};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rr_reg         <= '0;
      unit_start_reg <= '0;
      unit_v_reg     <= '0;
      unit_addr_reg  <= '0;
      dispatched_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
        unit_v_reg     <= head[ENTRY_W-1 -: V_W];
        unit_addr_reg  <= head[ADDRESS_WIDTH-1:0];
        unit_start_reg <= grant_onehot;
        rr_reg         <= rr_next;
        dispatched_reg <= dispatched_reg + 32'd1;
      end else begin
        unit_start_reg <= '0;
      end
    end
  end

  assign unitV       = unit_v_reg;
  assign unitAddress = unit_addr_reg;
  assign unitStart   = unit_start_reg;
  assign dispatched  = dispatched_reg;
  assign rayBusy     = (count_reg != '0) || (|unit_start_reg) || (|unitBusy);

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher: handshake, round-robin, backpressure,
// masking, asynchronous reset and a randomised frame drain.
module tb_ray_dispatcher;

  localparam int PW = 16;
  localparam int AW = 32;
  localparam int NU = 4;
  localparam int FD = 4;

  logic                        clock = 1'b0;
  logic                        reset;
  logic signed [2:0][PW-1:0]   rayV;
  logic        [AW-1:0]        rayAddress;
  logic                        rayStart;
  logic                        rayReady;
  logic                        rayBusy;
  logic signed [2:0][PW-1:0]   unitV;
  logic        [AW-1:0]        unitAddress;
  logic        [NU-1:0]        unitStart;
  logic        [NU-1:0]        unitReady;
  logic        [NU-1:0]        unitBusy;
  logic        [31:0]          dispatched;

  int checks = 0;
  int passes = 0;

  ray_dispatcher #(
    .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .NUM_UNITS(NU), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset),
    .rayV(rayV), .rayAddress(rayAddress), .rayStart(rayStart),
    .rayReady(rayReady), .rayBusy(rayBusy),
    .unitV(unitV), .unitAddress(unitAddress), .unitStart(unitStart),
    .unitReady(unitReady), .unitBusy(unitBusy), .dispatched(dispatched)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      passes++;
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    rayStart  = 1'b0;
    unitReady = '0;
    unitBusy  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive_ray(input logic [AW-1:0] addr, input int vx, input int vy, input int vz);
    rayStart   = 1'b1;
    rayAddress = addr;
    rayV[2]    = PW'(vx);
    rayV[1]    = PW'(vy);
    rayV[0]    = PW'(vz);
  endtask

  logic signed [2:0][PW-1:0] exp_v;
  int  busy_cnt [NU];
  logic ready_m [NU];
  int  pushed, delivered, done_cnt;
  logic will_push;

  initial begin
    reset      = 1'b1;
    rayStart   = 1'b0;
    rayV       = '0;
    rayAddress = '0;
    unitReady  = '0;
    unitBusy   = '0;
    #3;
    check("rst_ready", rayReady, 1'b1);
    check("rst_busy", rayBusy, 1'b0);
    check("rst_start", unitStart, '0);
    check("rst_addr", unitAddress, '0);
    check("rst_v", unitV, '0);
    check("rst_disp", dispatched, '0);
    step();
    reset = 1'b0;

    // Single ray, all units ready
    unitReady = 4'b1111;
    drive_ray(32'h1000, 100, -200, 300);
    step();
    rayStart = 1'b0;
    check("single_no_bypass", unitStart, 4'b0000);
    check("single_busy_buf", rayBusy, 1'b1);
    step();
    exp_v[2] = 16'sd100; exp_v[1] = -16'sd200; exp_v[0] = 16'sd300;
    check("single_start", unitStart, 4'b0001);
    check("single_v", unitV, exp_v);
    check("single_addr", unitAddress, 32'h1000);
    check("single_disp", dispatched, 32'd1);
    check("single_busy_start", rayBusy, 1'b1);
    unitReady = 4'b1110;
    unitBusy  = 4'b0001;
    step();
    check("single_start_off", unitStart, 4'b0000);
    check("single_busy_unit", rayBusy, 1'b1);
    unitBusy = 4'b0000;
    #1;
    check("single_idle", rayBusy, 1'b0);

    // Round-robin, one ray per cycle
    apply_reset();
    unitReady = 4'b1111;
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) drive_ray(32'h2000 + j, j, -j, 2 * j);
      else rayStart = 1'b0;
      step();
      if (j >= 1) begin
        check("rr_start", unitStart, 4'b0001 << ((j - 1) % 4));
        check("rr_addr", unitAddress, 32'h2000 + j - 1);
        check("rr_ready", rayReady, 1'b1);
      end
    end
    check("rr_disp", dispatched, 32'd8);

    // Backpressure
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      drive_ray(32'h3000 + j, j, j, j);
      check("bp_ready", rayReady, 1'b1);
      step();
    end
    drive_ray(32'h3004, 4, 4, 4);
    check("bp_full", rayReady, 1'b0);
    step();
    step();
    check("bp_hold_ready", rayReady, 1'b0);
    check("bp_hold_disp", dispatched, 32'd0);
    unitReady = 4'b0100;
    step();
    check("bp_start", unitStart, 4'b0100);
    check("bp_addr", unitAddress, 32'h3000);
    check("bp_ready_again", rayReady, 1'b1);
    unitReady = 4'b0000;
    step();
    rayStart = 1'b0;
    check("bp_refill", rayReady, 1'b0);
    check("bp_start_off", unitStart, 4'b0000);

    // Mask: one unit, no double issue
    apply_reset();
    unitReady = 4'b0010;
    drive_ray(32'h4000, 1, 2, 3);
    step();
    drive_ray(32'h4001, 4, 5, 6);
    step();
    rayStart = 1'b0;
    check("mask_start", unitStart, 4'b0010);
    check("mask_addr", unitAddress, 32'h4000);
    step();
    check("mask_blocked", unitStart, 4'b0000);
    check("mask_disp1", dispatched, 32'd1);
    unitReady = 4'b0000;
    step();
    step();
    check("mask_wait", unitStart, 4'b0000);
    check("mask_wait_disp", dispatched, 32'd1);
    unitReady = 4'b0010;
    step();
    check("mask_second", unitStart, 4'b0010);
    check("mask_second_addr", unitAddress, 32'h4001);
    check("mask_disp2", dispatched, 32'd2);

    // Asynchronous reset mid-operation
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      drive_ray(32'h5000 + j, j, j, j);
      step();
    end
    rayStart  = 1'b0;
    unitReady = 4'b0001;
    step();
    check("arst_pre_start", unitStart, 4'b0001);
    check("arst_pre_ready", rayReady, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_start", unitStart, 4'b0000);
    check("arst_ready", rayReady, 1'b1);
    check("arst_disp", dispatched, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    check("arst_empty_start", unitStart, 4'b0000);
    check("arst_empty_busy", rayBusy, 1'b0);
    check("arst_empty_disp", dispatched, 32'd0);

    // Frame drain: 12 rays, random unit readiness and busy time
    apply_reset();
    pushed = 0; delivered = 0; done_cnt = 0;
    for (int i = 0; i < NU; i++) begin
      busy_cnt[i] = 0;
      ready_m[i]  = 1'b0;
    end
    for (int cyc = 0; cyc < 400 && !(pushed == 12 && done_cnt == 12); cyc++) begin
      if (pushed < 12) drive_ray(32'h6000 + pushed, pushed, -pushed, 3 * pushed);
      else rayStart = 1'b0;
      for (int i = 0; i < NU; i++) begin
        unitReady[i] = ready_m[i];
        unitBusy[i]  = (busy_cnt[i] != 0);
      end
      #1;
      check("drain_busy", rayBusy, (pushed != done_cnt));
      will_push = rayStart && rayReady;
      step();
      if (will_push) pushed++;
      for (int i = 0; i < NU; i++) begin
        if (busy_cnt[i] > 0) begin
          busy_cnt[i]--;
          if (busy_cnt[i] == 0) done_cnt++;
        end
      end
      if (unitStart != '0) check("drain_onehot", $onehot(unitStart), 1'b1);
      for (int i = 0; i < NU; i++) begin
        if (unitStart[i]) begin
          check("drain_unit_ready", ready_m[i], 1'b1);
          check("drain_addr", unitAddress, 32'h6000 + delivered);
          delivered++;
          ready_m[i]  = 1'b0;
          busy_cnt[i] = int'($urandom_range(1, 3));
        end
      end
      for (int i = 0; i < NU; i++) begin
        if (!ready_m[i] && busy_cnt[i] == 0) ready_m[i] = 1'($urandom_range(0, 1));
      end
    end
    rayStart = 1'b0;
    for (int i = 0; i < NU; i++) unitBusy[i] = (busy_cnt[i] != 0);
    #1;
    check("drain_final_busy", rayBusy, 1'b0);
    check("drain_delivered", delivered, 12);
    check("drain_done", done_cnt, 12);
    check("drain_disp", dispatched, 32'd12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ray_dispatcher.md
Name: ray_dispatcher

Overview:
Responder end of the camera-ray interface. Accepts rays (direction plus frame-buffer pixel address) from the ray generator through the rayStart/rayReady handshake and buffers them in a small FIFO. Hands them out round-robin to NUM_UNITS ray units. Reports aggregate rayBusy back to the generator so it can tell when a frame is fully rendered.

Parameters:
POSITION_WIDTH, 16, width of each signed ray direction component
ADDRESS_WIDTH, 32, width of pixel address
NUM_UNITS, 4, number of downstream ray units (2..16)
FIFO_DEPTH, 4, ray buffer entries (power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rayV  in  signed POSITION_WIDTH x3  incoming ray direction {x,y,z}
rayAddress  in  ADDRESS_WIDTH  incoming pixel address
rayStart  in  1  incoming ray valid
rayReady  out  1  dispatcher can accept a ray this cycle
rayBusy  out  1  rays buffered, in flight, or any unit busy
unitV  out  signed POSITION_WIDTH x3  dispatched ray direction, shared by all units
unitAddress  out  ADDRESS_WIDTH  dispatched pixel address, shared
unitStart  out  NUM_UNITS  one-hot, one-cycle start pulse to the selected unit
unitReady  in  NUM_UNITS  unit i idle and able to take a ray
unitBusy  in  NUM_UNITS  unit i processing
dispatched  out  32  count of rays issued since reset

Behaviour:
- Reset (async, asserted high): FIFO empty (count=0, pointers=0), unitStart=0, unitV=0, unitAddress=0, round-robin pointer rr=0, mask=0, dispatched=0. Combinational outputs at reset: rayReady=1, rayBusy=OR(unitBusy).
- Upstream handshake:
  - Push on a rising edge when rayStart && rayReady.
  - rayReady = (count < FIFO_DEPTH); derived from registers only, never from rayStart.
  - rayStart with rayReady low: no push. Upstream holds its data.
- Eligibility: unit i is eligible in a cycle if unitReady[i] && !mask[i].
- Dispatch decision, made each cycle when count>0 and at least one unit is eligible:
  - Grant g = first eligible index searching rr, rr+1, ... mod NUM_UNITS.
  - At the edge: pop the FIFO head; unitV and unitAddress <= head; unitStart <= onehot(g); rr <= (g+1) mod NUM_UNITS; mask <= onehot(g); dispatched += 1.
- No dispatch in a cycle: unitStart <= 0; mask <= 0; unitV, unitAddress and rr hold.
- Mask purpose: a unit may still show unitReady during the cycle its start pulse is visible. The mask keeps the same unit from being granted twice back-to-back. Mask lasts exactly one cycle.
- Unit contract: unitReady[i] stays high until the unit samples unitStart[i]. A unit samples unitV and unitAddress on the cycle its unitStart is high.
- Latency: a ray pushed at edge k is dispatched at edge k+1 at the earliest (FIFO non-empty and an eligible unit). unitStart is high during cycle k+1..k+2. There is no bypass path.
- Throughput: one ray per cycle when at least two units alternate readiness.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into a full FIFO is impossible because rayReady=0. Pop from an empty FIFO never occurs.
- Pointers wrap modulo FIFO_DEPTH. dispatched wraps at 2^32.
- rayBusy = (count!=0) || (|unitStart) || (|unitBusy). It must stay high continuously from the first push until the last unit drops busy, so the generator never sees a false idle.
- Data is passed bit-exact: no arithmetic on rayV or rayAddress.
- Reset mid-operation: buffered rays are discarded and any unitStart is deasserted asynchronously. Units are reset by the same signal.

Test Plan:
- Single ray, all units ready: rayStart=1 with V={100,-200,300}, addr=0x1000 at edge 0 -> at edge 1 unitStart=4'b0001, unitV={100,-200,300}, unitAddress=0x1000; dispatched=1; rayBusy=1 until unitBusy falls and count=0.
- Round-robin: 8 consecutive rays with all unitReady held high -> unitStart sequence 0001,0010,0100,1000,0001,...; one ray per cycle; addresses in order.
- Backpressure: unitReady=0, push 5 rays -> rayReady=1 for the first 4 pushes, rayReady=0 after count=4, 5th held by upstream. Raise unitReady[2] -> unit 2 receives ray 0, then rayReady=1.
- Mask: only unit 1 ready, and it drops ready one cycle after its start pulse; 2 rays queued -> unit 1 gets exactly one start. The second ray waits until unitReady[1] rises again; no double issue.
- Reset mid-operation: 3 rays buffered, unitStart active, assert reset asynchronously mid-cycle -> unitStart=0 and rayReady=1 immediately; after release count=0 and dispatched=0.
- Frame drain: generator streams a 4x3 frame (12 rays) to 4 units with random ready/busy -> all 12 addresses are delivered exactly once, and rayBusy falls only after the final unitBusy deasserts.
